// File: rtl/split_stream_dispatch.sv
// Steers each whole AXI-Stream packet to one of four outputs, round-robin over eligible ports.
// Combinational pass-through once a port owns the packet; the owner's tready stalls the input.
module split_stream_dispatch #(
  parameter int         WIDTH       = 16,
  parameter logic [3:0] ACTIVE_MASK = 4'b1111,
  parameter int         CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [3:0]             port_enable,
  input  logic [WIDTH-1:0]       i_tdata,
  input  logic                   i_tlast,
  input  logic                   i_tvalid,
  output logic                   i_tready,
  output logic [WIDTH-1:0]       o0_tdata,
  output logic                   o0_tlast,
  output logic                   o0_tvalid,
  input  logic                   o0_tready,
  output logic [WIDTH-1:0]       o1_tdata,
  output logic                   o1_tlast,
  output logic                   o1_tvalid,
  input  logic                   o1_tready,
  output logic [WIDTH-1:0]       o2_tdata,
  output logic                   o2_tlast,
  output logic                   o2_tvalid,
  input  logic                   o2_tready,
  output logic [WIDTH-1:0]       o3_tdata,
  output logic                   o3_tlast,
  output logic                   o3_tvalid,
  input  logic                   o3_tready,
  output logic [1:0]             cur_port,
  output logic                   busy,
  output logic [4*CNT_WIDTH-1:0] pkt_count
);

  typedef enum logic {S_IDLE, S_PASS} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_last_port;
  logic [1:0]           r_cur_port;
  logic [CNT_WIDTH-1:0] r_cnt [4];

  logic [3:0] w_eligible;
  logic       w_any_elig;
  logic [1:0] w_sel;
  logic [1:0] w_idx;
  logic       w_found;
  logic       w_start;
  logic       w_pkt_end;
  logic [3:0] w_o_tready;
  logic [3:0] w_o_tvalid;
  logic [3:0] w_o_tlast;

  assign w_eligible = port_enable & ACTIVE_MASK;
  assign w_any_elig = |w_eligible;
  assign w_o_tready = {o3_tready, o2_tready, o1_tready, o0_tready};

  // First eligible port after the previous owner, wrapping mod 4.
  always_comb begin
    w_sel   = r_last_port;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last_port + 2'(k);
      if (!w_found && w_eligible[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_start   = (r_state == S_IDLE) && i_tvalid && w_any_elig;
  assign w_pkt_end = (r_state == S_PASS) && i_tvalid && i_tready && i_tlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_PASS;
      S_PASS:  if (w_pkt_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_o_tvalid = 4'b0000;
    w_o_tlast  = 4'b0000;
    i_tready   = 1'b0;
    if (r_state == S_PASS) begin
      w_o_tvalid[r_cur_port] = i_tvalid & ACTIVE_MASK[r_cur_port];
      w_o_tlast[r_cur_port]  = i_tlast;
      i_tready               = w_o_tready[r_cur_port];
    end
  end

  // Clear wins over a coincident end-of-packet handshake, so the count is not bumped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_port <= 2'd3;
      r_cur_port  <= 2'd0;
      for (int n = 0; n < 4; n++) r_cnt[n] <= '0;
    end else if (clear) begin
      r_last_port <= 2'd3;
      r_cur_port  <= 2'd0;
      for (int n = 0; n < 4; n++) r_cnt[n] <= '0;
    end else begin
      if (w_start) begin
        r_cur_port <= w_sel;
      end
      if (w_pkt_end) begin
        r_last_port       <= r_cur_port;
        r_cnt[r_cur_port] <= r_cnt[r_cur_port] + CNT_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
  end

  assign o0_tdata  = i_tdata;
  assign o1_tdata  = i_tdata;
  assign o2_tdata  = i_tdata;
  assign o3_tdata  = i_tdata;
  assign o0_tvalid = w_o_tvalid[0];
  assign o1_tvalid = w_o_tvalid[1];
  assign o2_tvalid = w_o_tvalid[2];
  assign o3_tvalid = w_o_tvalid[3];
  assign o0_tlast  = w_o_tlast[0];
  assign o1_tlast  = w_o_tlast[1];
  assign o2_tlast  = w_o_tlast[2];
  assign o3_tlast  = w_o_tlast[3];
  assign cur_port  = r_cur_port;
  assign busy      = (r_state == S_PASS);

endmodule

// File: tb/tb_split_stream_dispatch.sv
// Self-checking bench: two dispatcher instances (default and masked/narrow-counter) against a packet-level model.
module tb_split_stream_dispatch;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [3:0]  en;
  logic [15:0] tdata;
  logic        tlast, vld, sel_b;
  logic [3:0]  rdy;

  wire a_vld = vld & ~sel_b;
  wire b_vld = vld & sel_b;
  wire a_clr = clear & ~sel_b;
  wire b_clr = clear & sel_b;

  wire              a_rdy, b_rdy, a_busy, b_busy;
  wire [3:0]        a_v, a_l, b_v, b_l;
  wire [3:0][15:0]  a_d, b_d;
  wire [1:0]        a_cur, b_cur;
  wire [63:0]       a_cnt;
  wire [7:0]        b_cnt;

  wire              s_rdy  = sel_b ? b_rdy : a_rdy;
  wire              s_busy = sel_b ? b_busy : a_busy;
  wire [3:0]        s_v    = sel_b ? b_v : a_v;
  wire [3:0]        s_l    = sel_b ? b_l : a_l;
  wire [3:0][15:0]  s_d    = sel_b ? b_d : a_d;
  wire [1:0]        s_cur  = sel_b ? b_cur : a_cur;

  split_stream_dispatch dut (
    .clk(clk), .reset(reset), .clear(a_clr), .port_enable(en),
    .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(a_vld), .i_tready(a_rdy),
    .o0_tdata(a_d[0]), .o0_tlast(a_l[0]), .o0_tvalid(a_v[0]), .o0_tready(rdy[0]),
    .o1_tdata(a_d[1]), .o1_tlast(a_l[1]), .o1_tvalid(a_v[1]), .o1_tready(rdy[1]),
    .o2_tdata(a_d[2]), .o2_tlast(a_l[2]), .o2_tvalid(a_v[2]), .o2_tready(rdy[2]),
    .o3_tdata(a_d[3]), .o3_tlast(a_l[3]), .o3_tvalid(a_v[3]), .o3_tready(rdy[3]),
    .cur_port(a_cur), .busy(a_busy), .pkt_count(a_cnt)
  );

  split_stream_dispatch #(.WIDTH(16), .ACTIVE_MASK(4'b1011), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .clear(b_clr), .port_enable(en),
    .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(b_vld), .i_tready(b_rdy),
    .o0_tdata(b_d[0]), .o0_tlast(b_l[0]), .o0_tvalid(b_v[0]), .o0_tready(rdy[0]),
    .o1_tdata(b_d[1]), .o1_tlast(b_l[1]), .o1_tvalid(b_v[1]), .o1_tready(rdy[1]),
    .o2_tdata(b_d[2]), .o2_tlast(b_l[2]), .o2_tvalid(b_v[2]), .o2_tready(rdy[2]),
    .o3_tdata(b_d[3]), .o3_tlast(b_l[3]), .o3_tvalid(b_v[3]), .o3_tready(rdy[3]),
    .cur_port(b_cur), .busy(b_busy), .pkt_count(b_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Packet-level reference: previous owner and completed-packet counts per instance.
  int m_last [2];
  int m_cnt  [2][4];

  function automatic logic [3:0] mask_of(input int d);
    return (d != 0) ? 4'b1011 : 4'b1111;
  endfunction

  function automatic int mod_of(input int d);
    return (d != 0) ? 4 : 65536;
  endfunction

  function automatic int model_pick(input int d, input logic [3:0] e);
    logic [3:0] elig;
    elig = e & mask_of(d);
    for (int i = 1; i <= 4; i++)
      if (elig[(m_last[d] + i) % 4]) return (m_last[d] + i) % 4;
    return -1;
  endfunction

  function automatic void model_reset(input int d);
    m_last[d] = 3;
    for (int p = 0; p < 4; p++) m_cnt[d][p] = 0;
  endfunction

  function automatic int get_cnt(input int d, input int p);
    if (d != 0) return int'(b_cnt[p*2 +: 2]);
    return int'(a_cnt[p*16 +: 16]);
  endfunction

  task automatic check_counts(input string tag);
    int d;
    d = sel_b ? 1 : 0;
    for (int p = 0; p < 4; p++) begin
      n_tests++;
      if (get_cnt(d, p) !== m_cnt[d][p]) begin
        n_fail++;
        $display("FAIL %s pkt_count[%0d]: got %0d expected %0d", tag, p, get_cnt(d, p), m_cnt[d][p]);
      end
    end
  endtask

  // Sends one packet on the selected instance; drop_at/clr_at are beat indices (-1 = unused).
  task automatic send_pkt(input int len, input int mode, input int drop_at, input int clr_at);
    int d, p, beat, k, cyc;
    logic [3:0] pat;
    pat = 4'b1001;
    d = sel_b ? 1 : 0;
    p = model_pick(d, en);
    if (p < 0) begin
      n_tests++; n_fail++;
      $display("FAIL pick: stimulus has no eligible port en=%b", en);
      return;
    end
    vld = 1'b1; tdata = 16'($urandom); tlast = (len == 1); rdy = 4'hF; clear = 1'b0;
    #1;
    n_tests++;
    if (s_busy !== 1'b0 || s_rdy !== 1'b0 || s_v !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_select: busy=%b i_tready=%b tvalid=%b expected 0,0,0000", s_busy, s_rdy, s_v);
    end
    @(posedge clk); #1;
    cyc = 1;
    n_tests++;
    if (s_cur !== 2'(p) || s_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL select: cur_port=%0d busy=%b expected %0d,1", s_cur, s_busy, p);
    end
    beat = 0; k = 0;
    while (beat < len) begin
      if (k > 20 * len + 20) begin
        n_tests++; n_fail++;
        $display("FAIL timeout: packet stuck at beat %0d of %0d", beat, len);
        break;
      end
      tlast = (beat == len - 1);
      case (mode)
        1:       begin rdy = 4'hF; rdy[p] = pat[k % 4]; end
        2:       rdy = 4'($urandom);
        default: rdy = 4'hF;
      endcase
      if (beat == drop_at) en[p] = 1'b0;
      clear = (beat == clr_at);
      #1;
      n_tests++;
      if (s_busy !== 1'b1 || s_cur !== 2'(p)) begin
        n_fail++;
        $display("FAIL pass_state: busy=%b cur_port=%0d expected 1,%0d", s_busy, s_cur, p);
      end
      n_tests++;
      if (s_v !== 4'(1 << p)) begin
        n_fail++;
        $display("FAIL tvalid_route: got %b expected %b", s_v, 4'(1 << p));
      end
      n_tests++;
      if (s_d[p] !== tdata || s_l[p] !== tlast) begin
        n_fail++;
        $display("FAIL beat_data: tdata=%h tlast=%b expected %h,%b", s_d[p], s_l[p], tdata, tlast);
      end
      n_tests++;
      if (s_rdy !== rdy[p]) begin
        n_fail++;
        $display("FAIL tready_mirror: i_tready=%b expected %b", s_rdy, rdy[p]);
      end
      @(posedge clk); #1;
      cyc++; k++;
      if (clear) begin
        clear = 1'b0; vld = 1'b0; tlast = 1'b0;
        model_reset(d);
        #1;
        n_tests++;
        if (s_busy !== 1'b0 || s_rdy !== 1'b0 || s_cur !== 2'd0) begin
          n_fail++;
          $display("FAIL clear_state: busy=%b i_tready=%b cur_port=%0d expected 0,0,0", s_busy, s_rdy, s_cur);
        end
        check_counts("clear");
        return;
      end
      if (rdy[p]) begin
        beat++;
        tdata = 16'($urandom);
      end
    end
    vld = 1'b0; tlast = 1'b0;
    m_cnt[d][p] = (m_cnt[d][p] + 1) % mod_of(d);
    m_last[d] = p;
    if (mode == 0) begin
      n_tests++;
      if (cyc !== len + 1) begin
        n_fail++;
        $display("FAIL packet_cycles: got %0d expected %0d", cyc, len + 1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; vld = 1'b0; tlast = 1'b0; tdata = '0;
    en = 4'hF; rdy = 4'hF; sel_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset(0); model_reset(1);
    for (int d = 0; d < 2; d++) begin
      sel_b = (d != 0);
      vld = 1'b1;
      #1;
      n_tests++;
      if (s_rdy !== 1'b0 || s_busy !== 1'b0 || s_cur !== 2'd0 || s_v !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: i_tready=%b busy=%b cur=%0d tvalid=%b expected 0,0,0,0000",
                 d, s_rdy, s_busy, s_cur, s_v);
      end
      vld = 1'b0;
      check_counts("reset");
    end
    sel_b = 1'b0;
  endtask

  task automatic test_round_robin();
    sel_b = 1'b0; en = 4'hF;
    for (int i = 0; i < 8; i++) send_pkt(4, 0, -1, -1);
    check_counts("round_robin");
  endtask

  task automatic test_skip();
    sel_b = 1'b1; en = 4'b1110;
    for (int i = 0; i < 4; i++) send_pkt(3, 0, -1, -1);
    check_counts("skip");
    sel_b = 1'b0;
  endtask

  task automatic test_backpressure();
    sel_b = 1'b0; en = 4'hF;
    send_pkt(6, 1, -1, -1);
    check_counts("backpressure");
  endtask

  task automatic test_no_eligible();
    sel_b = 1'b0; en = 4'b0000; vld = 1'b1; tdata = 16'($urandom); tlast = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_tests++;
      if (s_rdy !== 1'b0 || s_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL no_eligible cycle %0d: i_tready=%b busy=%b expected 0,0", c, s_rdy, s_busy);
      end
      @(posedge clk); #1;
    end
    en = 4'b0100;
    send_pkt(3, 0, -1, -1);
    check_counts("no_eligible");
  endtask

  task automatic test_mid_enable();
    sel_b = 1'b0; en = 4'hF;
    send_pkt(5, 0, 2, -1);
    for (int i = 0; i < 4; i++) send_pkt(2, 0, -1, -1);
    check_counts("mid_enable");
  endtask

  task automatic test_clear();
    sel_b = 1'b0; en = 4'hF;
    send_pkt(8, 0, -1, 2);
    send_pkt(2, 0, -1, -1);
    check_counts("after_clear");
    send_pkt(3, 0, -1, 2);
    send_pkt(1, 0, -1, -1);
    check_counts("clear_on_last");
  endtask

  task automatic test_wrap();
    sel_b = 1'b1; en = 4'b0010;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset(1);
    for (int i = 0; i < 5; i++) send_pkt(1, 0, -1, -1);
    check_counts("wrap");
    sel_b = 1'b0;
  endtask

  task automatic test_random();
    sel_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      en = 4'($urandom);
      if (en == 4'b0) en = 4'b1000;
      send_pkt(int'($urandom_range(1, 6)), 2, -1, -1);
    end
    check_counts("random");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_skip();
    test_backpressure();
    test_no_eligible();
    test_mid_enable();
    test_clear();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
